// File: rtl/main_bus_arbiter_pkg.sv
// Shared main-bus definitions: arbiter state encoding and the burst length
// that the arbiter and memory controllers must agree on.
package mcDefs;
  typedef enum logic [1:0] {IDLE, GRANT, XFER, TURN} arb_state_t;
  localparam int BURST_LEN = 4;
endpackage

// File: rtl/main_bus_arbiter_if.sv
// Main bus arbitration signals. Masters drive req/AddrValid; the arbiter
// returns grant and status.
interface main_bus_arbiter_if #(parameter int NUM_MASTERS = 4);
  localparam int IDW = $clog2(NUM_MASTERS);
  logic [NUM_MASTERS-1:0] req;
  logic                   AddrValid;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDW-1:0]         gnt_id;
  logic                   busy;
  logic                   timeout;
  logic                   proto_err;

  modport master (output req, AddrValid,
                  input  grant, gnt_id, busy, timeout, proto_err);
  modport slave  (input  req, AddrValid,
                  output grant, gnt_id, busy, timeout, proto_err);
endinterface

// File: rtl/main_bus_arbiter_rr_picker.sv
// Round-robin pick: first set req bit searching upward from last_id+1, wrapping.
module main_bus_arbiter_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IDW         = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDW-1:0]         last_id,
  output logic                   vld,
  output logic [IDW-1:0]         id
);
  int             idx;
  logic [IDW-1:0] idx_w;

  // Scan farthest-first so the nearest candidate overwrites and wins.
  always_comb begin
    vld   = 1'b0;
    id    = last_id;
    idx   = 0;
    idx_w = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = int'(last_id) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      idx_w = IDW'(idx);
      if (req[idx_w]) begin
        vld = 1'b1;
        id  = idx_w;
      end
    end
  end
endmodule

// File: rtl/main_bus_arbiter.sv
// Round-robin main bus arbiter: grant -> address cycle -> burst -> one
// turnaround cycle; unused grants are revoked after TIMEOUT cycles.
module main_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int BURST_LEN   = mcDefs::BURST_LEN,
  parameter int TIMEOUT     = 8
) (
  input  logic               clk,
  input  logic               resetH,
  main_bus_arbiter_if.slave  bus
);
  import mcDefs::*;

  localparam int IDW = $clog2(NUM_MASTERS);
  localparam int WW  = $clog2(TIMEOUT);
  localparam int BW  = $clog2(BURST_LEN + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]         gnt_id_q, gnt_id_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic                   proto_err_q, proto_err_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [BW-1:0]          burst_q, burst_d;

  logic                   pick_vld;
  logic [IDW-1:0]         pick_id;

  main_bus_arbiter_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .IDW(IDW)) u_pick (
    .req     (bus.req),
    .last_id (gnt_id_q),
    .vld     (pick_vld),
    .id      (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    proto_err_d = bus.AddrValid && (state_q != GRANT);
    wait_d      = wait_q;
    burst_d     = burst_q;
    case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        state_d = IDLE;
        if (pick_vld) begin
          state_d          = GRANT;
          grant_d[pick_id] = 1'b1;
          gnt_id_d         = pick_id;
        end
      end
      GRANT: begin
        wait_d = wait_q + WW'(1);
        // Address strobe beats both withdrawal and timeout in the same cycle.
        if (bus.AddrValid) begin
          state_d = XFER;
        end else if (!bus.req[gnt_id_q]) begin
          state_d = TURN;
          grant_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = TURN;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      XFER: begin
        if (burst_q == BURST_LAST) begin
          state_d = TURN;
          grant_d = '0;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      wait_d  = '0;
      burst_d = '0;
    end
    busy_d = (state_d == GRANT) || (state_d == XFER);
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gnt_id_q    <= IDW'(NUM_MASTERS - 1);
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      wait_q      <= '0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      wait_q      <= wait_d;
      burst_q     <= burst_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
  assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter: round-robin order, turnaround, timeout,
// withdrawal, protocol errors and asynchronous reset.
module tb_main_bus_arbiter;
  localparam int NM = 4;

  logic clk;
  logic resetH;
  int   n_tests;
  int   n_fail;

  main_bus_arbiter_if #(.NUM_MASTERS(NM)) bus();

  main_bus_arbiter #(.NUM_MASTERS(NM), .BURST_LEN(4), .TIMEOUT(8)) dut (
    .clk    (clk),
    .resetH (resetH),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetH = 1'b1;
    tick();
    tick();
    resetH = 1'b0;
  endtask

  // Entered at the first GRANT cycle of master m; leaves in the TURN cycle.
  task automatic do_txn(input int m, input logic [NM-1:0] req_after);
    logic [NM-1:0] oh;
    oh = '0;
    oh[m] = 1'b1;
    chk("txn_grant", 32'(bus.grant), 32'(oh));
    chk("txn_id", 32'(bus.gnt_id), 32'(m));
    chk("txn_busy_g", 32'(bus.busy), 32'd1);
    bus.AddrValid = 1'b1;
    tick();
    bus.AddrValid = 1'b0;
    bus.req = req_after;
    for (int k = 0; k < 4; k++) begin
      chk("xfer_grant", 32'(bus.grant), 32'(oh));
      chk("xfer_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    chk("turn_grant", 32'(bus.grant), 32'd0);
    chk("turn_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.req = '0;
    bus.AddrValid = 1'b0;
    do_reset();

    // Reset state
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_id", 32'(bus.gnt_id), 32'd3);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);
    chk("rst_perr", 32'(bus.proto_err), 32'd0);

    // Single master, one-cycle grant latency
    bus.req = 4'b0001;
    tick();
    do_txn(0, 4'b0000);
    tick();
    chk("idle_grant", 32'(bus.grant), 32'd0);

    // All requesting: 0,1,2,3,0 with one dead cycle each
    do_reset();
    bus.req = 4'b1111;
    tick();
    do_txn(0, 4'b1111);
    tick();
    do_txn(1, 4'b1111);
    tick();
    do_txn(2, 4'b1111);
    tick();
    do_txn(3, 4'b1111);
    tick();
    do_txn(0, 4'b0000);
    tick();

    // Unused grant revoked after 8 cycles, then re-granted
    bus.req = 4'b0100;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("to_hold", 32'(bus.grant), 32'h4);
      chk("to_nopulse", 32'(bus.timeout), 32'd0);
      tick();
    end
    chk("to_grant", 32'(bus.grant), 32'd0);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    tick();
    chk("to_regrant", 32'(bus.grant), 32'h4);
    chk("to_pulse_end", 32'(bus.timeout), 32'd0);
    bus.req = 4'b0000;
    tick();
    tick();

    // Withdrawal before AddrValid: no timeout, next master granted
    bus.req = 4'b0011;
    tick();
    chk("wd_grant0", 32'(bus.grant), 32'h1);
    bus.req = 4'b0010;
    tick();
    chk("wd_turn", 32'(bus.grant), 32'd0);
    chk("wd_noto", 32'(bus.timeout), 32'd0);
    tick();
    do_txn(1, 4'b0000);
    tick();

    // Protocol errors in IDLE and XFER
    bus.AddrValid = 1'b1;
    tick();
    bus.AddrValid = 1'b0;
    chk("perr_idle", 32'(bus.proto_err), 32'd1);
    chk("perr_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("perr_clear", 32'(bus.proto_err), 32'd0);
    bus.req = 4'b0001;
    tick();
    chk("perr_grant", 32'(bus.grant), 32'h1);
    bus.AddrValid = 1'b1;
    tick();
    bus.AddrValid = 1'b0;
    bus.req = 4'b0000;
    chk("perr_x1", 32'(bus.proto_err), 32'd0);
    tick();
    bus.AddrValid = 1'b1;
    tick();
    bus.AddrValid = 1'b0;
    chk("perr_x3", 32'(bus.proto_err), 32'd1);
    chk("perr_x3_grant", 32'(bus.grant), 32'h1);
    tick();
    chk("perr_x4_grant", 32'(bus.grant), 32'h1);
    chk("perr_x4_perr", 32'(bus.proto_err), 32'd0);
    tick();
    chk("perr_turn", 32'(bus.grant), 32'd0);
    tick();

    // Asynchronous reset during XFER cycle 3
    bus.req = 4'b0010;
    tick();
    chk("ar_grant", 32'(bus.grant), 32'h2);
    bus.AddrValid = 1'b1;
    tick();
    bus.AddrValid = 1'b0;
    tick();
    tick();
    chk("ar_x3_busy", 32'(bus.busy), 32'd1);
    resetH = 1'b1;
    #1;
    chk("ar_grant0", 32'(bus.grant), 32'd0);
    chk("ar_busy0", 32'(bus.busy), 32'd0);
    chk("ar_id", 32'(bus.gnt_id), 32'd3);
    tick();
    resetH = 1'b0;
    bus.req = 4'b1000;
    tick();
    chk("ar_after_grant", 32'(bus.grant), 32'h8);
    chk("ar_after_id", 32'(bus.gnt_id), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/main_bus_arbiter.md
Name: main_bus_arbiter

Overview:
- Round-robin arbiter that shares the main bus between NUM_MASTERS bus masters (CPUs, DMA) in front of the page-decoded memory controllers.
- Grants exclusive bus ownership for one complete transaction: one AddrValid cycle followed by BURST_LEN data cycles.
- Inserts one turnaround cycle after each transaction to prevent AddrData tristate contention.
- Revokes a grant that is never used.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- BURST_LEN, 4, data cycles following the AddrValid cycle; must match the memory controller burst.
- TIMEOUT, 8, cycles a granted master may hold grant without asserting AddrValid (≥2).

Ports:
- clk  input  1  main bus clock (MBUS.clk).
- resetH  input  1  asynchronous active-high reset (MBUS.resetH).
- req  input  NUM_MASTERS  per-master request, level; held until transaction is done.
- AddrValid  input  1  main bus address strobe, monitored only.
- grant  output  NUM_MASTERS  one-hot registered grant; at most one bit high.
- gnt_id  output  $clog2(NUM_MASTERS)  index of current/last winner.
- busy  output  1  high in GRANT and XFER.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.
- proto_err  output  1  one-cycle pulse when AddrValid is sampled outside GRANT.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, resetH.
- Reset values: state=IDLE, grant=0, gnt_id=NUM_MASTERS-1, busy=0, timeout=0, proto_err=0, counters=0.
- Reset asserted mid-transaction clears everything immediately, with no completion of the burst.
- All outputs are registered.
- States: IDLE, GRANT, XFER, TURN.
- Arbitration runs in IDLE and TURN:
  - Search req starting at (gnt_id+1) mod NUM_MASTERS, wrapping.
  - First set bit wins. The winner's grant bit is set and gnt_id is updated at the same edge; state becomes GRANT.
  - Req-to-grant latency is 1 cycle from IDLE.
  - If no req is set, TURN goes to IDLE and IDLE stays in IDLE.
- GRANT:
  - grant held. Wait counter increments each cycle.
  - AddrValid=1: go to XFER, clear the burst counter. AddrValid takes priority over the same-cycle timeout and over the same-cycle req drop.
  - Else if req[gnt_id]=0: master withdrew; go to TURN, grant=0, no timeout pulse.
  - Else if wait counter == TIMEOUT-1: go to TURN, grant=0, timeout pulse.
- XFER:
  - grant held for exactly BURST_LEN cycles; req changes are ignored.
  - At burst counter == BURST_LEN-1: go to TURN, grant cleared.
  - AddrValid sampled in XFER: proto_err pulse, state unaffected.
- TURN:
  - grant=0 for exactly one cycle; arbitration is evaluated in this cycle.
  - Back-to-back transactions therefore have exactly one dead cycle between the last data cycle and the next grant.
- Fairness: a master that just won is lowest priority next round, including after a timeout or withdrawal.
- AddrValid in IDLE or TURN: proto_err pulse only.
- Counter widths: $clog2(TIMEOUT) and $clog2(BURST_LEN+1). Neither counter wraps; both are cleared on each state entry.

Decomposition:
- mcDefs package gets:
  - arb_state_t enum {IDLE, GRANT, XFER, TURN}.
  - localparam BURST_LEN = 4, shared with memory_if.
- One sub-module, rr_picker: combinational rotate-and-priority-encode. Inputs req and last id; outputs a valid flag and the winner id.

Test Plan:
- Reset then req=4'b0001, AddrValid at grant+1: grant=0001 one cycle after req; busy for 1 GRANT + 4 XFER cycles; then 1 TURN cycle with grant=0.
- req=4'b1111 held, each master completes transactions: grant order 0,1,2,3,0. Each grant follows the previous burst end after exactly 1 dead cycle.
- req=4'b0100, master never asserts AddrValid: grant=0100 for 8 cycles; then timeout pulse with grant=0. With req still high and others idle, master 2 is re-granted after TURN.
- req=4'b0011; granted master 0 drops req before AddrValid: TURN with no timeout; master 1 granted next.
- AddrValid pulsed in IDLE and during XFER cycle 2: proto_err pulse at each; XFER still lasts 4 cycles.
- resetH asserted during XFER cycle 3: grant=0, busy=0, state IDLE immediately, asynchronously. After release, req=1000 is granted in 1 cycle and gnt_id=3.
